// File: rtl/deltasigma_decim.sv
// deltasigma_decim: third-order CIC (sinc3) decimator, 1-bit bitstream in, one OUT_W sample per R = 2^OSR clocks.
// Latency: out/out_valid update on the tick edge itself, the R-th clk after reset release and every R clks after.
// Backpressure: none; out_valid is a one-cycle strobe and the consumer must take every sample.
// Optional feature macro DELTASIGMA_SIGNED_EN: maps in to +1/-1 and sign-extends out.
module deltasigma_decim #(
    parameter int OSR   = 3,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid
);

`ifdef DELTASIGMA_SIGNED_EN
    // One extra bit so -R^3..+R^3 fits in two's complement.
    localparam int W = 3*OSR + 2;
`else
    localparam int W = 3*OSR + 1;
`endif

    // Reject unsupported configurations at elaboration time.
    generate
        if (OSR < 1 || OSR > 6) begin : g_bad_osr
            $error("deltasigma_decim: OSR must be in 1..6");
        end
        if (OUT_W < 3*OSR + 2) begin : g_bad_out_w
            $error("deltasigma_decim: OUT_W must be at least 3*OSR+2");
        end
    endgenerate

    logic [OSR-1:0] cnt;
    logic           tick;
    logic [W-1:0]   x;
    logic [W-1:0]   i1, i2, i3;
    logic [W-1:0]   d1, d2, d3;
    logic [W-1:0]   c1, c2, c3;

    // The last count of each frame is the decimation tick; cnt wraps naturally at R.
    assign tick = &cnt;

    // Map the modulator bit to the integrator input and form the comb differences.
    // All arithmetic wraps modulo 2^W on purpose: the comb section cancels integrator overflow.
    always_comb begin
`ifdef DELTASIGMA_SIGNED_EN
        x = in ? W'(1) : {W{1'b1}};
`else
        x = {{(W-1){1'b0}}, in};
`endif
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    // Integrator cascade and decimation counter, running at the full bit rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
            i1  <= i1 + x;
            i2  <= i2 + i1;
            i3  <= i3 + i2;
        end
    end

    // Comb delay line and output register, advanced only on the decimation tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else if (tick) begin
            d1        <= i3;
            d2        <= c1;
            d3        <= c2;
`ifdef DELTASIGMA_SIGNED_EN
            out       <= OUT_W'($signed(c3));
`else
            out       <= OUT_W'(c3);
`endif
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_deltasigma_decim.sv
// tb_deltasigma_decim: directed bench for deltasigma_decim (OSR=3, R=8).
// Reference: output equals the input sequence convolved with the sinc3 kernel (three length-R boxcars).
// Per-cycle comparison of out/out_valid plus literal expectations for key points.
module tb_deltasigma_decim;

    localparam int OSR   = 3;
    localparam int OUT_W = 20;
    localparam int R     = 1 << OSR;
    localparam int FULL  = R * R * R;

`ifdef DELTASIGMA_SIGNED_EN
    localparam logic [OUT_W-1:0] EXP_ONES = 20'd512;
    localparam logic [OUT_W-1:0] EXP_ZERO = 20'hFFE00;
    localparam logic [OUT_W-1:0] EXP_ALT  = 20'd0;
`else
    localparam logic [OUT_W-1:0] EXP_ONES = 20'd512;
    localparam logic [OUT_W-1:0] EXP_ZERO = 20'd0;
    localparam logic [OUT_W-1:0] EXP_ALT  = 20'd256;
`endif

    logic             clk;
    logic             rst;
    logic             in;
    logic [OUT_W-1:0] out;
    logic             out_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state: inputs seen since the last reset and edge count.
    int               xs[$];
    int               e_cnt;
    logic [OUT_W-1:0] exp_out;
    logic             exp_vld;
    bit               rng_chk;

    deltasigma_decim #(.OSR(OSR), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number of ways three values in 0..R-1 sum to p: the sinc3 kernel tap.
    function automatic int kern(input int p);
        int n = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                if (p - a - b >= 0 && p - a - b < R) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, got, want, e_cnt);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic cyc(input logic r, input logic v);
        int y;
        int x;
        rst = r;
        in  = v;
        @(posedge clk);
        if (r) begin
            xs.delete();
            e_cnt   = 0;
            exp_out = '0;
            exp_vld = 1'b0;
        end else begin
`ifdef DELTASIGMA_SIGNED_EN
            x = v ? 1 : -1;
`else
            x = v ? 1 : 0;
`endif
            xs.push_back(x);
            e_cnt++;
            if (e_cnt % R == 0) begin
                y = 0;
                for (int j = 0; j < e_cnt; j++) begin
                    int p;
                    p = e_cnt - 4 - j;
                    if (p >= 0 && p <= 3*R - 3) y += xs[j] * kern(p);
                end
                exp_out = y[OUT_W-1:0];
                exp_vld = 1'b1;
            end else begin
                exp_vld = 1'b0;
            end
        end
        #1;
        chk("out", out, exp_out);
        chk("out_valid", {{(OUT_W-1){1'b0}}, out_valid}, {{(OUT_W-1){1'b0}}, exp_vld});
        if (rng_chk && out_valid) begin
            checks++;
`ifdef DELTASIGMA_SIGNED_EN
            if ($signed(out) > FULL || $signed(out) < -FULL) begin
`else
            if (out > OUT_W'(FULL)) begin
`endif
                errors++;
                $display("FAIL range: out %0h outside full scale %0d", out, FULL);
            end
        end
    endtask

    task automatic run(input logic v, input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, v);
    endtask

    // Release reset with in=1 and measure the first strobe position and value.
    task automatic first_strobe(input string tag);
        int k;
        k = 0;
        for (int t = 1; t <= 20; t++) begin
            cyc(1'b0, 1'b1);
            if (out_valid) begin
                k = t;
                break;
            end
        end
        chk({tag, "_first_strobe_edge"}, OUT_W'(k), OUT_W'(8));
        chk({tag, "_first_strobe_value"}, out, 20'd35);
    endtask

    initial begin
        rst     = 1'b1;
        in      = 1'b0;
        rng_chk = 1'b0;
        e_cnt   = 0;
        exp_out = '0;
        exp_vld = 1'b0;

        // Reset held three clocks with random input.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'($urandom_range(0, 1)));
        chk("reset_out", out, 20'd0);
        chk("reset_valid", {19'd0, out_valid}, 20'd0);

        // Constant ones: first strobe on the 8th edge, settles to full scale.
        first_strobe("start");
        run(1'b1, 72);
        chk("const_one", out, EXP_ONES);
        chk("const_one_upper_bits", {10'd0, out[OUT_W-1:10]}, {10'd0, EXP_ONES[OUT_W-1:10]});

        // Constant zeros.
        run(1'b0, 80);
        chk("const_zero", out, EXP_ZERO);

        // Alternating every clock.
        for (int k = 0; k < 40; k++) begin
            cyc(1'b0, 1'b1);
            cyc(1'b0, 1'b0);
        end
        chk("alternate", out, EXP_ALT);

        // Slow square wave, then zeros, then ones, with full-scale range watch.
        rng_chk = 1'b1;
        for (int k = 0; k < 11; k++) run(1'((k + 1) % 2), 8);
        run(1'b0, 88);
        chk("square_then_zero", out, EXP_ZERO);
        run(1'b1, 88);
        chk("square_then_one", out, EXP_ONES);
        rng_chk = 1'b0;

        // Mid-run reset from full scale: history must be gone.
        cyc(1'b1, 1'b1);
        chk("midreset_out", out, 20'd0);
        chk("midreset_valid", {19'd0, out_valid}, 20'd0);
        first_strobe("midreset");
        run(1'b1, 72);
        chk("midreset_settle", out, EXP_ONES);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
